// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_ALUI, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
  } cls_e;

  localparam logic [4:0] ALU_NOP = 5'd0,  ALU_ADD = 5'd1,  ALU_SUB = 5'd2,
                         ALU_AND = 5'd3,  ALU_OR  = 5'd4,  ALU_XOR = 5'd5,
                         ALU_NOR = 5'd6,  ALU_SLT = 5'd7,  ALU_SLTU = 5'd8,
                         ALU_SLL = 5'd9,  ALU_SRL = 5'd10, ALU_SRA = 5'd11,
                         ALU_LUI = 5'd12;

  localparam logic [3:0] NPC_PLUS4 = 4'd0, NPC_BRANCH = 4'd1, NPC_JUMP = 4'd2,
                         NPC_JR    = 4'd3, NPC_JALR   = 4'd4;

  localparam logic [1:0] GPRSEL_RD = 2'd0, GPRSEL_RT = 2'd1, GPRSEL_31 = 2'd2;
  localparam logic [1:0] WDSEL_ALU = 2'd0, WDSEL_MEM = 2'd1, WDSEL_PC  = 2'd2;

  // Word accesses (lw and sw) share code 0.
  localparam logic [3:0] LD_W = 4'd0, LD_B = 4'd1, LD_BU = 4'd2, LD_H = 4'd3,
                         LD_HU = 4'd4, ST_B = 4'd5, ST_H = 4'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - unified memory port handshake between control and memory
interface mc_ctrl_if;
  logic MemRead;
  logic MemWrite;
  logic IorD;
  logic mem_ready;

  modport master (output MemRead, output MemWrite, output IorD, input mem_ready);
  modport slave  (input MemRead, input MemWrite, input IorD, output mem_ready);
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - Op/Funct to instruction class, ALU op, extension and load size
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic [4:0] alu_op,
  output logic       ext_op,
  output logic [3:0] load_sel
);

  // Pure table lookup; anything not listed is illegal.
  always_comb begin
    cls      = C_ILLEGAL;
    alu_op   = ALU_NOP;
    ext_op   = 1'b1;
    load_sel = LD_W;
    case (op)
      OP_RTYPE: begin
        cls = C_RTYPE;
        case (funct)
          6'h20, 6'h21:     alu_op = ALU_ADD;
          6'h22, 6'h23:     alu_op = ALU_SUB;
          6'h24:            alu_op = ALU_AND;
          6'h25:            alu_op = ALU_OR;
          6'h26:            alu_op = ALU_XOR;
          6'h27:            alu_op = ALU_NOR;
          6'h2a:            alu_op = ALU_SLT;
          6'h2b:            alu_op = ALU_SLTU;
          6'h00:            alu_op = ALU_SLL;
          6'h02:            alu_op = ALU_SRL;
          6'h03:            alu_op = ALU_SRA;
          FN_JR, FN_JALR:   cls = C_JUMP;
          default:          cls = C_ILLEGAL;
        endcase
      end
      OP_J, OP_JAL:     cls = C_JUMP;
      OP_BEQ, OP_BNE: begin cls = C_BRANCH; alu_op = ALU_SUB; end
      6'h08, 6'h09:   begin cls = C_ALUI; alu_op = ALU_ADD; end
      6'h0a:          begin cls = C_ALUI; alu_op = ALU_SLT; end
      6'h0b:          begin cls = C_ALUI; alu_op = ALU_SLTU; end
      6'h0c:          begin cls = C_ALUI; alu_op = ALU_AND; ext_op = 1'b0; end
      6'h0d:          begin cls = C_ALUI; alu_op = ALU_OR;  ext_op = 1'b0; end
      6'h0e:          begin cls = C_ALUI; alu_op = ALU_XOR; ext_op = 1'b0; end
      6'h0f:          begin cls = C_ALUI; alu_op = ALU_LUI; ext_op = 1'b0; end
      6'h20:          begin cls = C_LOAD;  alu_op = ALU_ADD; load_sel = LD_B;  end
      6'h21:          begin cls = C_LOAD;  alu_op = ALU_ADD; load_sel = LD_H;  end
      6'h23:          begin cls = C_LOAD;  alu_op = ALU_ADD; load_sel = LD_W;  end
      6'h24:          begin cls = C_LOAD;  alu_op = ALU_ADD; load_sel = LD_BU; end
      6'h25:          begin cls = C_LOAD;  alu_op = ALU_ADD; load_sel = LD_HU; end
      6'h28:          begin cls = C_STORE; alu_op = ALU_ADD; load_sel = ST_B;  end
      6'h29:          begin cls = C_STORE; alu_op = ALU_ADD; load_sel = ST_H;  end
      6'h2b:          begin cls = C_STORE; alu_op = ALU_ADD; load_sel = LD_W;  end
      default:        cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with memory-wait timeout
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  mc_ctrl_if.master  mem,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [4:0] ALUOp,
  output logic [3:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [3:0] LOADSel,
  output logic       illegal,
  output logic       err,
  output logic [2:0] state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  cls_e       dec_cls;
  logic [4:0] dec_alu;
  logic       dec_ext;
  logic [3:0] dec_ls;

  mc_ctrl_decode u_decode (
    .op       (Op),
    .funct    (Funct),
    .cls      (dec_cls),
    .alu_op   (dec_alu),
    .ext_op   (dec_ext),
    .load_sel (dec_ls)
  );

  assign state = state_q;

  // State and wait counter; reset drops any in-flight memory request at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and per-state strobes; the counter only survives a waiting cycle,
  // so any entry into FETCH or MEM starts it from zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'd0;
    EXTOp        = 1'b0;
    ALUOp        = ALU_NOP;
    NPCOp        = NPC_PLUS4;
    GPRSel       = GPRSEL_RD;
    WDSel        = WDSEL_ALU;
    LOADSel      = LD_W;
    illegal      = 1'b0;
    err          = 1'b0;
    mem.MemRead  = 1'b0;
    mem.MemWrite = 1'b0;
    mem.IorD     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.MemRead = 1'b1;
        if (mem.mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == TO_LAST) begin
          err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        state_d = S_EXEC;
        if (dec_cls == C_JUMP) begin
          PCWrite = 1'b1;
          state_d = S_FETCH;
          if (Op == OP_J) begin
            NPCOp = NPC_JUMP;
          end else if (Op == OP_JAL) begin
            NPCOp    = NPC_JUMP;
            RegWrite = 1'b1;
            GPRSel   = GPRSEL_31;
            WDSel    = WDSEL_PC;
          end else if (Funct == FN_JR) begin
            NPCOp = NPC_JR;
          end else begin
            NPCOp    = NPC_JALR;
            RegWrite = 1'b1;
            GPRSel   = GPRSEL_RD;
            WDSel    = WDSEL_PC;
          end
        end else if (dec_cls == C_ILLEGAL) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (dec_cls == C_RTYPE || dec_cls == C_BRANCH) ? 2'd0 : 2'd2;
        EXTOp   = dec_ext;
        ALUOp   = dec_alu;
        case (dec_cls)
          C_BRANCH: begin
            NPCOp   = NPC_BRANCH;
            PCWrite = (Op == OP_BEQ) ? Zero : ~Zero;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem.IorD     = 1'b1;
        mem.MemRead  = (dec_cls == C_LOAD);
        mem.MemWrite = (dec_cls == C_STORE);
        LOADSel      = dec_ls;
        if (mem.mem_ready) begin
          state_d = (dec_cls == C_STORE) ? S_FETCH : S_WB;
        end else if (cnt_q == TO_LAST) begin
          err     = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        GPRSel   = (dec_cls == C_RTYPE) ? GPRSEL_RD : GPRSEL_RT;
        WDSel    = (dec_cls == C_LOAD) ? WDSEL_MEM : WDSEL_ALU;
        LOADSel  = dec_ls;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, RegWrite, ALUSrcA, EXTOp, illegal, err;
  logic [1:0] ALUSrcB, GPRSel, WDSel;
  logic [4:0] ALUOp;
  logic [3:0] NPCOp, LOADSel;
  logic [2:0] state;

  mc_ctrl_if mif ();

  mc_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem(mif),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel),
    .WDSel(WDSel), .LOADSel(LOADSel), .illegal(illegal), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                 K_J = 5, K_JAL = 6, K_JR = 7, K_JALR = 8, K_ILL = 9;
  localparam logic [7:0] B_PCW = 8'h80, B_IRW = 8'h40, B_MR = 8'h20, B_MW = 8'h10,
                         B_IORD = 8'h08, B_RW = 8'h04, B_ILL = 8'h02, B_ERR = 8'h01;
  localparam int NPOOL = 25;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] alu;
    logic       ext;
    logic [3:0] ls;
  } ins_t;

  typedef struct {
    logic [2:0] st;
    logic       rdy;
    logic [7:0] str;
    logic [3:0] npc;  logic chk_npc;
    logic [1:0] gsel; logic [1:0] wdsel; logic chk_wb;
    logic [4:0] alu;  logic srca; logic [1:0] srcb; logic chk_alu;
    logic       ext;  logic chk_ext;
    logic [3:0] ls;   logic chk_ls;
  } step_t;

  step_t tr[$];

  // Instruction pool: opcode, funct, expected ALU operation, sign-extend, access size.
  function automatic ins_t pick(input int i);
    ins_t r;
    r.fn = 6'($urandom);
    r.ext = 1'b1; r.ls = LD_W; r.alu = ALU_ADD;
    case (i)
      0:  begin r.op = 6'h00; r.fn = 6'h21; end
      1:  begin r.op = 6'h00; r.fn = 6'h23; r.alu = ALU_SUB; end
      2:  begin r.op = 6'h00; r.fn = 6'h24; r.alu = ALU_AND; end
      3:  begin r.op = 6'h00; r.fn = 6'h25; r.alu = ALU_OR;  end
      4:  begin r.op = 6'h00; r.fn = 6'h2a; r.alu = ALU_SLT; end
      5:  begin r.op = 6'h00; r.fn = 6'h00; r.alu = ALU_SLL; end
      6:  begin r.op = 6'h00; r.fn = 6'h03; r.alu = ALU_SRA; end
      7:  begin r.op = 6'h09; end
      8:  begin r.op = 6'h0c; r.alu = ALU_AND; r.ext = 1'b0; end
      9:  begin r.op = 6'h0d; r.alu = ALU_OR;  r.ext = 1'b0; end
      10: begin r.op = 6'h0f; r.alu = ALU_LUI; r.ext = 1'b0; end
      11: begin r.op = 6'h0a; r.alu = ALU_SLT; end
      12: begin r.op = 6'h23; end
      13: begin r.op = 6'h20; r.ls = LD_B; end
      14: begin r.op = 6'h25; r.ls = LD_HU; end
      15: begin r.op = 6'h2b; end
      16: begin r.op = 6'h28; r.ls = ST_B; end
      17: begin r.op = 6'h04; r.alu = ALU_SUB; end
      18: begin r.op = 6'h05; r.alu = ALU_SUB; end
      19: begin r.op = 6'h02; end
      20: begin r.op = 6'h03; end
      21: begin r.op = 6'h00; r.fn = 6'h08; end
      22: begin r.op = 6'h00; r.fn = 6'h09; end
      23: begin r.op = 6'h3f; end
      default: begin r.op = 6'h00; r.fn = 6'h3f; end
    endcase
    return r;
  endfunction

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
        6'h08: return K_JR;
        6'h09: return K_JALR;
        6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: return K_R;
        default: return K_ILL;
      endcase
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04, 6'h05: return K_BR;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: return K_I;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return K_LD;
      6'h28, 6'h29, 6'h2b: return K_ST;
      default: return K_ILL;
    endcase
  endfunction

  function automatic step_t mk(input logic [2:0] st, input logic rdy, input logic [7:0] str);
    step_t s;
    s.st = st; s.rdy = rdy; s.str = str;
    s.npc = '0; s.chk_npc = 1'b0;
    s.gsel = '0; s.wdsel = '0; s.chk_wb = 1'b0;
    s.alu = '0; s.srca = 1'b0; s.srcb = '0; s.chk_alu = 1'b0;
    s.ext = 1'b0; s.chk_ext = 1'b0;
    s.ls = '0; s.chk_ls = 1'b0;
    return s;
  endfunction

  // Expected cycle-by-cycle trace of one instruction: the state walk and strobes
  // follow the instruction class; wf/wm are wait cycles in FETCH/MEM.
  task automatic build(input ins_t ins, input logic z, input int wf, input int wm);
    int    k = kind(ins.op, ins.fn);
    step_t s;
    logic  [7:0] acc;
    tr.delete();
    for (int i = 0; i < wf; i++) tr.push_back(mk(3'd0, 1'b0, B_MR));
    s = mk(3'd0, 1'b1, B_MR | B_IRW | B_PCW);
    s.npc = NPC_PLUS4; s.chk_npc = 1'b1;
    tr.push_back(s);
    s = mk(3'd1, 1'($urandom), 8'h00);
    s.alu = ALU_ADD; s.srca = 1'b0; s.srcb = 2'd3; s.chk_alu = 1'b1;
    case (k)
      K_J:    begin s.str = B_PCW; s.npc = NPC_JUMP; s.chk_npc = 1'b1; end
      K_JAL:  begin s.str = B_PCW | B_RW; s.npc = NPC_JUMP; s.chk_npc = 1'b1;
                    s.gsel = GPRSEL_31; s.wdsel = WDSEL_PC; s.chk_wb = 1'b1; end
      K_JR:   begin s.str = B_PCW; s.npc = NPC_JR; s.chk_npc = 1'b1; end
      K_JALR: begin s.str = B_PCW | B_RW; s.npc = NPC_JALR; s.chk_npc = 1'b1;
                    s.gsel = GPRSEL_RD; s.wdsel = WDSEL_PC; s.chk_wb = 1'b1; end
      K_ILL:  s.str = B_ILL;
      default: ;
    endcase
    tr.push_back(s);
    if (k >= K_J) return;
    s = mk(3'd2, 1'($urandom), 8'h00);
    s.alu = ins.alu; s.srca = 1'b1; s.chk_alu = 1'b1;
    s.srcb = (k == K_R || k == K_BR) ? 2'd0 : 2'd2;
    s.ext = ins.ext; s.chk_ext = (k != K_R);
    if (k == K_BR) begin
      s.str = (((ins.op == 6'h04) ? z : !z)) ? B_PCW : 8'h00;
      s.npc = NPC_BRANCH; s.chk_npc = 1'b1;
      tr.push_back(s);
      return;
    end
    tr.push_back(s);
    if (k == K_LD || k == K_ST) begin
      acc = B_IORD | ((k == K_LD) ? B_MR : B_MW);
      for (int i = 0; i <= wm; i++) begin
        s = mk(3'd3, (i == wm), acc);
        s.ls = ins.ls; s.chk_ls = 1'b1;
        tr.push_back(s);
      end
      if (k == K_ST) return;
    end
    s = mk(3'd4, 1'($urandom), B_RW);
    s.gsel = (k == K_R) ? GPRSEL_RD : GPRSEL_RT;
    s.wdsel = (k == K_LD) ? WDSEL_MEM : WDSEL_ALU;
    s.chk_wb = 1'b1;
    tr.push_back(s);
  endtask

  // Entered just after a rising edge with the DUT freshly in FETCH.
  task automatic run_instr(input string name, input int idx, input logic z,
                           input int wf, input int wm);
    ins_t       ins = pick(idx);
    logic [7:0] got;
    build(ins, z, wf, wm);
    Op = ins.op; Funct = ins.fn; Zero = z;
    foreach (tr[i]) begin
      mif.mem_ready = tr[i].rdy;
      @(negedge clk);
      got = {PCWrite, IRWrite, mif.MemRead, mif.MemWrite, mif.IorD, RegWrite, illegal, err};
      n_cmp++;
      if (state !== tr[i].st || got !== tr[i].str) begin
        n_bad++;
        $display("FAIL %s step %0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                 name, i, state, got, tr[i].st, tr[i].str);
      end
      if (tr[i].chk_npc) begin
        n_cmp++;
        if (NPCOp !== tr[i].npc) begin
          n_bad++;
          $display("FAIL %s step %0d npc: got %0d expected %0d", name, i, NPCOp, tr[i].npc);
        end
      end
      if (tr[i].chk_wb) begin
        n_cmp++;
        if ({GPRSel, WDSel} !== {tr[i].gsel, tr[i].wdsel}) begin
          n_bad++;
          $display("FAIL %s step %0d wb_sel: got gpr=%0d wd=%0d expected gpr=%0d wd=%0d",
                   name, i, GPRSel, WDSel, tr[i].gsel, tr[i].wdsel);
        end
      end
      if (tr[i].chk_alu) begin
        n_cmp++;
        if ({ALUOp, ALUSrcA, ALUSrcB} !== {tr[i].alu, tr[i].srca, tr[i].srcb}) begin
          n_bad++;
          $display("FAIL %s step %0d alu: got op=%0d a=%0d b=%0d expected op=%0d a=%0d b=%0d",
                   name, i, ALUOp, ALUSrcA, ALUSrcB, tr[i].alu, tr[i].srca, tr[i].srcb);
        end
      end
      if (tr[i].chk_ext) begin
        n_cmp++;
        if (EXTOp !== tr[i].ext) begin
          n_bad++;
          $display("FAIL %s step %0d ext: got %0d expected %0d", name, i, EXTOp, tr[i].ext);
        end
      end
      if (tr[i].chk_ls) begin
        n_cmp++;
        if (LOADSel !== tr[i].ls) begin
          n_bad++;
          $display("FAIL %s step %0d loadsel: got %0d expected %0d", name, i, LOADSel, tr[i].ls);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (state !== 3'd0) begin
      n_bad++;
      $display("FAIL %s end_state: got %0d expected 0", name, state);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; mif.mem_ready = 1'b0; Op = 6'h00; Funct = 6'h00; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 3'd0 || {PCWrite, IRWrite, mif.MemRead, mif.MemWrite, mif.IorD,
                           RegWrite, illegal, err} !== B_MR) begin
      n_bad++;
      $display("FAIL reset_hold: state=%0d MemRead=%b IorD=%b expected state=0 MemRead=1 IorD=0",
               state, mif.MemRead, mif.IorD);
    end
    @(negedge clk); rstn = 1'b1;
    // Walk a store into MEM and hold it there.
    Op = 6'h2b;
    @(posedge clk); #1; mif.mem_ready = 1'b1;
    @(posedge clk); #1; mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 3'd3 || mif.MemWrite !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_setup: state=%0d MemWrite=%b expected state=3 MemWrite=1", state, mif.MemWrite);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (state !== 3'd0 || mif.MemWrite !== 1'b0 || mif.MemRead !== 1'b1 || mif.IorD !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_mem: state=%0d MemWrite=%b MemRead=%b IorD=%b expected 0 0 1 0",
               state, mif.MemWrite, mif.MemRead, mif.IorD);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 3'd0 || mif.MemRead !== 1'b1 || mif.IorD !== 1'b0 || PCWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: state=%0d MemRead=%b IorD=%b expected state=0 MemRead=1 IorD=0",
               state, mif.MemRead, mif.IorD);
    end
  endtask

  task automatic test_addu();     run_instr("addu", 0, 1'b0, 0, 0); endtask
  task automatic test_lw_wait();  run_instr("lw_wait3", 12, 1'b0, 0, 3); endtask
  task automatic test_beq();
    run_instr("beq_taken", 17, 1'b1, 0, 0);
    run_instr("beq_not_taken", 17, 1'b0, 0, 0);
  endtask
  task automatic test_jal();      run_instr("jal", 20, 1'b0, 0, 0); endtask
  task automatic test_illegal();  run_instr("illegal_op", 23, 1'b0, 0, 0); endtask

  task automatic test_timeout();
    logic exp_err;
    mif.mem_ready = 1'b0; Op = 6'h2b;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      exp_err = (c == 16);
      n_cmp++;
      if ({state, PCWrite, IRWrite, err} !== {3'd0, 1'b0, 1'b0, exp_err}) begin
        n_bad++;
        $display("FAIL fetch_timeout cycle %0d: state=%0d pcw=%b irw=%b err=%b expected err=%b",
                 c, state, PCWrite, IRWrite, err, exp_err);
      end
      @(posedge clk); #1;
    end
    mif.mem_ready = 1'b1;
    @(posedge clk); #1; mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_err = (c == 16);
      n_cmp++;
      if ({state, mif.IorD, err} !== {3'd3, 1'b1, exp_err}) begin
        n_bad++;
        $display("FAIL mem_timeout cycle %0d: state=%0d iord=%b err=%b expected state=3 err=%b",
                 c, state, mif.IorD, err, exp_err);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if ({state, mif.MemWrite, mif.MemRead, RegWrite, PCWrite, err} !== {3'd0, 5'b01000}) begin
      n_bad++;
      $display("FAIL mem_timeout_exit: state=%0d mw=%b mr=%b rw=%b pcw=%b err=%b expected 0 0 1 0 0 0",
               state, mif.MemWrite, mif.MemRead, RegWrite, PCWrite, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      run_instr("random", $urandom_range(0, NPOOL - 1), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
